trap_sequencer: RTL
===================

Name: trap_sequencer

Overview:
Machine-mode interrupt entry/return controller for the BearCore-V 5-stage pipeline. It synchronizes the timer, external and software IRQ lines and selects the highest-priority enabled one. It halts fetch, waits for the pipeline to drain, then commits trap state to the CSR block and redirects the PC. It also sequences MRET return and WFI sleep, replacing the ad-hoc interrupt_taken/PC-mux logic in the core.

Parameters:
SYNC_STAGES, 2, flops in each IRQ synchronizer (>=1)
DRAIN_MAX, 15, cycles allowed in HALT before drain_err_o is raised

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
timer_irq_i  in  1  raw level IRQ, cause 7
ext_irq_i  in  1  raw level IRQ, cause 11
sw_irq_i  in  1  raw level IRQ, cause 3
mstatus_mie_i  in  1  global enable from CSR
mie_i  in  32  per-source enables; bits 3/7/11 used
mtvec_i  in  32  [31:2] base, [1:0] mode (0 direct, 1 vectored)
mepc_i  in  32  return address from CSR
fetch_pc_i  in  32  next PC IF would fetch
pipe_empty_i  in  1  no valid instruction in ID/EX/MEM/WB
mret_i  in  1  one-cycle pulse, MRET in EX
wfi_i  in  1  one-cycle pulse, WFI in EX
fetch_halt_o  out  1  stall IF
flush_o  out  1  kill IF/ID/EX, one cycle
pc_load_o  out  1  load pc_target_o into PC, one cycle
pc_target_o  out  32  redirect target
csr_trap_we_o  out  1  CSR: write mepc/mcause, MPIE<=MIE, MIE<=0
csr_mepc_o  out  32  value for mepc
csr_mcause_o  out  32  {1'b1, 27'b0, cause[3:0]}
csr_mret_o  out  1  CSR: MIE<=MPIE, MPIE<=1
wfi_sleep_o  out  1  core sleeping
drain_err_o  out  1  sticky drain-timeout flag
busy_o  out  1  state != IDLE

Behaviour:
- All outputs reset to 0. State resets to IDLE. Reset mid-sequence aborts with no CSR write.
- Sync: each IRQ goes through SYNC_STAGES flops. pend[k] = sync[k] & mie_i[k].
- Priority, highest first: ext(11) > sw(3) > timer(7).
- States: IDLE, HALT, COMMIT, REDIRECT, RET, SLEEP. All outputs are registered.
- IDLE:
  - mret_i -> RET. MRET wins over a same-cycle interrupt.
  - else any pend & mstatus_mie_i -> HALT.
  - else wfi_i -> SLEEP.
  - Raw IRQ rise to fetch_halt_o=1 takes SYNC_STAGES+1 cycles.
- HALT:
  - fetch_halt_o=1, drain counter runs.
  - pipe_empty_i=1 -> COMMIT. Latch mepc=fetch_pc_i and the winning cause at that edge.
  - If no pend remains at that edge (level dropped), abort to IDLE with fetch_halt_o deasserted; the trap is spurious and no CSR write occurs.
  - Counter hits DRAIN_MAX -> set drain_err_o (cleared only by reset). Keep waiting.
  - mret_i in HALT is impossible by construction (pipe draining); it is ignored.
- COMMIT (1 cycle):
  - csr_trap_we_o=1, csr_mepc_o/csr_mcause_o driven, fetch_halt_o=1.
  - Target = base if mode 0, base+4*cause if mode 1. Use 32-bit wrap arithmetic; mode values 2/3 are treated as direct.
  - Next state REDIRECT.
- REDIRECT (1 cycle): pc_load_o=1, flush_o=1, pc_target_o=target, fetch_halt_o=0 -> IDLE. Pending is not sampled in this cycle, because the CSR MIE clear lands on the COMMIT edge.
- RET (1 cycle): pc_load_o=1, flush_o=1, csr_mret_o=1, pc_target_o=mepc_i -> IDLE. An enabled pending IRQ re-enters via IDLE no earlier than the cycle after RET.
- SLEEP:
  - fetch_halt_o=1, wfi_sleep_o=1.
  - Exits to IDLE when any pend is set, independent of mstatus_mie_i.
  - If MIE=1 the trap follows from IDLE next cycle; otherwise execution resumes at fetch_pc_i with no redirect.

Decomposition:
- Package bearcore_irq_pkg holds:
  - cause constants CAUSE_MSI=3, CAUSE_MTI=7, CAUSE_MEI=11
  - MTVEC_DIRECT/MTVEC_VECTORED
  - the state enum
  - an mcause-build function
- Sub-module irq_sync (SYNC_STAGES-deep single-bit synchronizer), instantiated three times.

Test Plan:
- Direct mode: mtvec=0x0000_0100, MIE=1, mie[7]=1, pulse timer high.
  - Expect fetch_halt_o at +3 cycles.
  - After pipe_empty_i: csr_trap_we_o with mcause=0x8000_0007 and mepc=fetch_pc_i (0x0000_0040).
  - Next cycle: pc_load_o with target 0x0000_0100.
- Vectored mode, mtvec=0x0000_0201: raise ext and timer together.
  - Expect mcause=0x8000_000B and target 0x0000_022C.
  - Timer stays pending and is not taken until MRET.
- MRET: mepc_i=0x0000_0044, pulse mret_i.
  - Expect next cycle pc_load_o=flush_o=csr_mret_o=1 and target 0x0000_0044.
  - With timer still pending and MIE restored, HALT is entered 1 cycle later.
- Spurious IRQ: hold pipe_empty_i=0 and drop timer during HALT, then assert pipe_empty_i.
  - Expect no csr_trap_we_o, return to IDLE, fetch_halt_o=0.
  - Separately, hold pipe_empty_i=0 for 20 cycles -> drain_err_o=1 at cycle 15 and stays set.
- WFI with MIE=0: pulse wfi_i -> wfi_sleep_o=1; raise sw_irq with mie[3]=1 -> wake to IDLE with no trap.
  - Repeat with MIE=1 -> trap with mcause=0x8000_0003.
  - Assert rst_n=0 during COMMIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/bearcore_irq_pkg.sv
// Shared definitions for the BearCore-V machine-mode interrupt sequencer.
//   - mcause exception codes of the three machine-level interrupt sources
//   - mtvec mode encodings
//   - trap sequencer state encoding
//   - helpers that build mcause and the trap target address
package bearcore_irq_pkg;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_COMMIT,
    ST_REDIRECT,
    ST_RET,
    ST_SLEEP
  } trap_state_e;

  // Interrupt flag in bit 31, exception code in the low nibble.
  function automatic logic [31:0] build_mcause(input logic [3:0] cause);
    return {1'b1, 27'b0, cause};
  endfunction

  // Only mode 1 vectors; the reserved modes 2/3 fall back to direct.
  // The add wraps at 32 bits.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic [3:0]  cause);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == MTVEC_VECTORED) return base + {26'b0, cause, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Single-bit level synchronizer, SYNC_STAGES flops deep.
//   clk, rst_n : clock, asynchronous active-low reset (chain clears to 0)
//   level      : raw asynchronous level
//   synced     : level after SYNC_STAGES clock edges
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic synced
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain[0] <= level;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign synced = chain[SYNC_STAGES-1];

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode interrupt entry/return controller for the BearCore-V pipeline.
// Synchronizes timer/external/software IRQs, picks the highest-priority
// enabled one (ext > sw > timer), halts fetch until the pipeline drains,
// commits mepc/mcause to the CSR block and redirects the PC. Also sequences
// MRET return and WFI sleep. Every output is a flop.
//   Inputs : clk, rst_n, timer/ext/sw_irq_i (raw levels), mstatus_mie_i,
//            mie_i, mtvec_i, mepc_i, fetch_pc_i, pipe_empty_i,
//            mret_i / wfi_i (one-cycle pulses from EX)
//   Outputs: fetch_halt_o, flush_o, pc_load_o, pc_target_o, csr_trap_we_o,
//            csr_mepc_o, csr_mcause_o, csr_mret_o, wfi_sleep_o,
//            drain_err_o (sticky until reset), busy_o
module trap_sequencer
  import bearcore_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DRAIN_MAX   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        timer_irq_i,
  input  logic        ext_irq_i,
  input  logic        sw_irq_i,
  input  logic        mstatus_mie_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        pipe_empty_i,
  input  logic        mret_i,
  input  logic        wfi_i,
  output logic        fetch_halt_o,
  output logic        flush_o,
  output logic        pc_load_o,
  output logic [31:0] pc_target_o,
  output logic        csr_trap_we_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o,
  output logic        csr_mret_o,
  output logic        wfi_sleep_o,
  output logic        drain_err_o,
  output logic        busy_o
);

  localparam int                CNT_W    = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DRAIN_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DRAIN_MAX);

  logic timer_sync, ext_sync, sw_sync;
  logic pend_mti, pend_mei, pend_msi, any_pend;
  logic [3:0] win_cause;
  logic unused_mie;

  trap_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        fetch_halt_d, flush_d, pc_load_d, csr_trap_we_d, csr_mret_d;
  logic        wfi_sleep_d, drain_err_d, busy_d;
  logic [31:0] pc_target_d, csr_mepc_d, csr_mcause_d;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_timer (
    .clk(clk), .rst_n(rst_n), .level(timer_irq_i), .synced(timer_sync));
  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (
    .clk(clk), .rst_n(rst_n), .level(ext_irq_i), .synced(ext_sync));
  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sw (
    .clk(clk), .rst_n(rst_n), .level(sw_irq_i), .synced(sw_sync));

  assign pend_mti = timer_sync & mie_i[CAUSE_MTI];
  assign pend_mei = ext_sync   & mie_i[CAUSE_MEI];
  assign pend_msi = sw_sync    & mie_i[CAUSE_MSI];
  assign any_pend = pend_mti | pend_mei | pend_msi;

  // Only the three machine-level enable bits matter here.
  assign unused_mie = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

  always_comb begin
    win_cause = CAUSE_MTI;
    if (pend_mei)      win_cause = CAUSE_MEI;
    else if (pend_msi) win_cause = CAUSE_MSI;
  end

  // Outputs are flops, so each one-cycle output value is produced on the
  // transition that enters the state owning it.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    drain_err_d   = drain_err_o;
    flush_d       = 1'b0;
    pc_load_d     = 1'b0;
    pc_target_d   = '0;
    csr_trap_we_d = 1'b0;
    csr_mepc_d    = '0;
    csr_mcause_d  = '0;
    csr_mret_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mret_i) begin
          state_d     = ST_RET;
          pc_load_d   = 1'b1;
          flush_d     = 1'b1;
          csr_mret_d  = 1'b1;
          pc_target_d = mepc_i;
        end else if (any_pend && mstatus_mie_i) begin
          state_d = ST_HALT;
        end else if (wfi_i) begin
          state_d = ST_SLEEP;
        end
      end

      ST_HALT: begin
        if (pipe_empty_i) begin
          if (any_pend) begin
            state_d       = ST_COMMIT;
            csr_trap_we_d = 1'b1;
            csr_mepc_d    = fetch_pc_i;
            csr_mcause_d  = build_mcause(win_cause);
          end else begin
            // Source level dropped while draining: spurious, no CSR write.
            state_d = ST_IDLE;
          end
        end else begin
          if (cnt_q >= CNT_LAST) drain_err_d = 1'b1;
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end

      ST_COMMIT: begin
        state_d     = ST_REDIRECT;
        pc_load_d   = 1'b1;
        flush_d     = 1'b1;
        pc_target_d = trap_target(mtvec_i, csr_mcause_o[3:0]);
      end

      // Pending is deliberately not looked at here: the MIE clear from
      // COMMIT is only visible to IDLE.
      ST_REDIRECT: state_d = ST_IDLE;

      ST_RET: state_d = ST_IDLE;

      // Wake on any enabled source regardless of global MIE.
      ST_SLEEP: if (any_pend) state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    fetch_halt_d = (state_d == ST_HALT) || (state_d == ST_COMMIT) ||
                   (state_d == ST_SLEEP);
    wfi_sleep_d  = (state_d == ST_SLEEP);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      fetch_halt_o  <= 1'b0;
      flush_o       <= 1'b0;
      pc_load_o     <= 1'b0;
      pc_target_o   <= '0;
      csr_trap_we_o <= 1'b0;
      csr_mepc_o    <= '0;
      csr_mcause_o  <= '0;
      csr_mret_o    <= 1'b0;
      wfi_sleep_o   <= 1'b0;
      drain_err_o   <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fetch_halt_o  <= fetch_halt_d;
      flush_o       <= flush_d;
      pc_load_o     <= pc_load_d;
      pc_target_o   <= pc_target_d;
      csr_trap_we_o <= csr_trap_we_d;
      csr_mepc_o    <= csr_mepc_d;
      csr_mcause_o  <= csr_mcause_d;
      csr_mret_o    <= csr_mret_d;
      wfi_sleep_o   <= wfi_sleep_d;
      drain_err_o   <= drain_err_d;
      busy_o        <= busy_d;
    end
  end

endmodule
